datapath_regs: RTL
==================

# datapath_regs

Register bank and internal bus of one processor core, directly downstream of `controlUnit`. Each cycle it applies the control unit's `wrEnReg`, `incReg`, `busSel` and `ZWrEn` strobes to the core's ten architectural registers and the Z flag. It drives the shared bus, and returns the instruction register and Z flag to the control unit. It also presents AR/PC/R/AC to data memory, instruction memory and the ALU.

## Interface
- `REG_WIDTH`, 12: width of the bus and every register except IR.
- `IR_WIDTH`, 8: width of IR, equal to `controlUnit` `IR_WIDTH`.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high; clears all state.
- `wrEnReg`  in  10: write enables {AR, R, PC, IR, RL, RC, RP, RQ, R1, AC}, bit 9 = AR.
- `incReg`  in  4: increment enables {PC, RC, RP, RQ}, bit 3 = PC.
- `busSel`  in  `bus_in_sel_t`: bus source select.
- `ZWrEn`  in  1: load Z flag from `aluZ`.
- `aluOut`  in  REG_WIDTH: ALU result; sole input to AC.
- `aluZ`  in  1: ALU zero indication.
- `dataMemOut`  in  REG_WIDTH: data memory read data.
- `insMemOut`  in  IR_WIDTH: instruction memory read data.
- `bus`  out  REG_WIDTH: internal bus, combinational from `busSel` and registers.
- `ins`  out  IR_WIDTH: IR contents, to `controlUnit.ins`.
- `Zout`  out  1: Z flag, to `controlUnit.Zout`.
- `dataMemAddr`  out  REG_WIDTH: AR.
- `dataMemIn`  out  REG_WIDTH: R.
- `insMemAddr`  out  REG_WIDTH: PC.
- `acOut`  out  REG_WIDTH: AC, to ALU operand A.

## Operation
- Bus mux by `busSel`:
  - `BUS_DM` selects dataMemOut.
  - `BUS_IM` selects insMemOut, zero-extended.
  - `BUS_R`, `BUS_RL`, `BUS_RC`, `BUS_RP`, `BUS_RQ`, `BUS_R1`, `BUS_AC`, `BUS_PC`, `BUS_AR`, `BUS_IR` select that register; IR is zero-extended.
  - Any undefined encoding drives all zeros.
- Writes:
  - AC loads `aluOut` when its enable is set.
  - IR loads `bus[IR_WIDTH-1:0]`.
  - Every other register loads the full bus.
- Increments: PC, RC, RP, RQ add 1 modulo 2^REG_WIDTH when their `incReg` bit is set; all-ones wraps to 0.
- Same register with write and increment enabled in one cycle: the write wins and the increment is dropped.
- A register read onto the bus and written in the same cycle captures the pre-edge value, so `MV` via bus needs no bubble.
- Z flag loads `aluZ` when `ZWrEn` is set and holds otherwise.
- Any combination of enables across different registers is legal simultaneously.

## Timing
- Reset: every register, Z, `ins`, `Zout`, `dataMemAddr`, `dataMemIn`, `insMemAddr` and `acOut` become 0 immediately on `rst` assertion, independent of `clk`.
- Reset is released on the first rising edge after `rst` deasserts; enables present at that edge take effect.
- Reset asserted mid-instruction aborts all pending updates; no write or increment occurs while `rst` is high.
- Write/increment latency is 1 cycle: the new value is visible on outputs right after the enabling edge.
- Bus latency is 0 (combinational).
- No handshakes: the strobes are single-cycle pulses owned by `controlUnit`, and the block acts on every cycle they are high.

## Structure
- `details` package gains:
  - `bus_in_sel_t` (4-bit enum, encodings above).
  - Localparam bit indices for `wrEnReg` (AR_IDX=9 … AC_IDX=0) and `incReg` (PC_INC=3 … RQ_INC=0).
- One sub-module, `inc_reg`: a parameterised width register with async active-high reset, load (priority), increment and data in. It is instantiated for PC, RC, RP and RQ.
- The remaining registers are plain enable flops inside `datapath_regs`.

## Test plan
- Reset: drive `rst`=1 mid-cycle with all registers non-zero. Every output reads 0 before the next edge.
- Load/move: `busSel`=BUS_DM with `dataMemOut`=12'h0A5 and RL write enabled for one cycle. Then `busSel`=BUS_RL with RP write enabled. RP=12'h0A5 two cycles after start; bus shows 12'h0A5 in the second cycle.
- Increment wrap: load PC=12'hFFF, then pulse `incReg[3]`. `insMemAddr`=12'h000 and other registers are unchanged.
- Write-vs-increment collision: RC=5, `busSel`=BUS_DM, `dataMemOut`=9, with RC write and RC inc both high. RC=9, not 6 or 10.
- IR and Z:
  - `busSel`=BUS_IM with `insMemOut`=8'h3F and IR write enabled gives `ins`=8'h3F.
  - `aluZ`=1 with `ZWrEn` pulsed gives `Zout`=1.
  - `aluZ`=0 with `ZWrEn`=0 leaves `Zout` at 1.
- AC path: `aluOut`=12'h123 with AC write enabled, then `busSel`=BUS_AC with R1 write enabled. `acOut`=12'h123, then R1=12'h123; `bus` reads 0 for undefined `busSel`=4'hF.

Source files
------------

// File: rtl/datapath_regs_pkg.sv
// Shared types and bit positions for the core's register bank.
//   bus_in_sel_t : source select for the internal bus (4-bit encoding)
//   *_IDX        : bit positions inside wrEnReg (AR is the MSB)
//   *_INC        : bit positions inside incReg  (PC is the MSB)
package details;

  typedef enum logic [3:0] {
    BUS_DM = 4'd0,
    BUS_IM = 4'd1,
    BUS_R  = 4'd2,
    BUS_RL = 4'd3,
    BUS_RC = 4'd4,
    BUS_RP = 4'd5,
    BUS_RQ = 4'd6,
    BUS_R1 = 4'd7,
    BUS_AC = 4'd8,
    BUS_PC = 4'd9,
    BUS_AR = 4'd10,
    BUS_IR = 4'd11
  } bus_in_sel_t;

  localparam int AR_IDX = 9;
  localparam int R_IDX  = 8;
  localparam int PC_IDX = 7;
  localparam int IR_IDX = 6;
  localparam int RL_IDX = 5;
  localparam int RC_IDX = 4;
  localparam int RP_IDX = 3;
  localparam int RQ_IDX = 2;
  localparam int R1_IDX = 1;
  localparam int AC_IDX = 0;

  localparam int PC_INC = 3;
  localparam int RC_INC = 2;
  localparam int RP_INC = 1;
  localparam int RQ_INC = 0;

endpackage

// File: rtl/datapath_regs_inc_reg.sv
// inc_reg: WIDTH-bit register with load and increment.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture d (takes priority over inc)
//   inc      : add 1, wrapping modulo 2^WIDTH
//   d        : load data
//   q        : register contents
module inc_reg #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = d;
    end else if (inc) begin
      val_d = val_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/datapath_regs.sv
// datapath_regs: architectural register bank, Z flag and internal bus.
//   clk, rst      : clock, asynchronous active-high reset
//   wrEnReg[9:0]  : write enables {AR,R,PC,IR,RL,RC,RP,RQ,R1,AC}
//   incReg[3:0]   : increment enables {PC,RC,RP,RQ}
//   busSel        : bus source select
//   ZWrEn, aluZ   : Z flag load strobe and its data
//   aluOut        : AC load data
//   dataMemOut    : data memory read data
//   insMemOut     : instruction memory read data
//   bus           : internal bus (combinational)
//   ins, Zout     : IR and Z back to the control unit
//   dataMemAddr   : AR
//   dataMemIn     : R
//   insMemAddr    : PC
//   acOut         : AC
module datapath_regs
  import details::*;
#(
  parameter int REG_WIDTH = 12,
  parameter int IR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           wrEnReg,
  input  logic [3:0]           incReg,
  input  bus_in_sel_t          busSel,
  input  logic                 ZWrEn,
  input  logic [REG_WIDTH-1:0] aluOut,
  input  logic                 aluZ,
  input  logic [REG_WIDTH-1:0] dataMemOut,
  input  logic [IR_WIDTH-1:0]  insMemOut,
  output logic [REG_WIDTH-1:0] bus,
  output logic [IR_WIDTH-1:0]  ins,
  output logic                 Zout,
  output logic [REG_WIDTH-1:0] dataMemAddr,
  output logic [REG_WIDTH-1:0] dataMemIn,
  output logic [REG_WIDTH-1:0] insMemAddr,
  output logic [REG_WIDTH-1:0] acOut
);

  localparam int PAD = REG_WIDTH - IR_WIDTH;

  logic [REG_WIDTH-1:0] ar_d, ar_q;
  logic [REG_WIDTH-1:0] r_d, r_q;
  logic [REG_WIDTH-1:0] rl_d, rl_q;
  logic [REG_WIDTH-1:0] r1_d, r1_q;
  logic [REG_WIDTH-1:0] ac_d, ac_q;
  logic [IR_WIDTH-1:0]  ir_d, ir_q;
  logic                 z_d, z_q;

  logic [REG_WIDTH-1:0] pc_q, rc_q, rp_q, rq_q;

  // Bus is driven from pre-edge register values, so a bus move lands in
  // the destination on the same edge without a bubble.
  always_comb begin
    bus = '0;
    case (busSel)
      BUS_DM:  bus = dataMemOut;
      BUS_IM:  bus = {{PAD{1'b0}}, insMemOut};
      BUS_R:   bus = r_q;
      BUS_RL:  bus = rl_q;
      BUS_RC:  bus = rc_q;
      BUS_RP:  bus = rp_q;
      BUS_RQ:  bus = rq_q;
      BUS_R1:  bus = r1_q;
      BUS_AC:  bus = ac_q;
      BUS_PC:  bus = pc_q;
      BUS_AR:  bus = ar_q;
      BUS_IR:  bus = {{PAD{1'b0}}, ir_q};
      default: bus = '0;
    endcase
  end

  always_comb begin
    ar_d = wrEnReg[AR_IDX] ? bus : ar_q;
    r_d  = wrEnReg[R_IDX]  ? bus : r_q;
    rl_d = wrEnReg[RL_IDX] ? bus : rl_q;
    r1_d = wrEnReg[R1_IDX] ? bus : r1_q;
    ac_d = wrEnReg[AC_IDX] ? aluOut : ac_q;
    ir_d = wrEnReg[IR_IDX] ? bus[IR_WIDTH-1:0] : ir_q;
    z_d  = ZWrEn ? aluZ : z_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q <= '0;
      r_q  <= '0;
      rl_q <= '0;
      r1_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
      z_q  <= 1'b0;
    end else begin
      ar_q <= ar_d;
      r_q  <= r_d;
      rl_q <= rl_d;
      r1_q <= r1_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
      z_q  <= z_d;
    end
  end

  inc_reg #(.WIDTH(REG_WIDTH)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (wrEnReg[PC_IDX]),
    .inc  (incReg[PC_INC]),
    .d    (bus),
    .q    (pc_q)
  );

  inc_reg #(.WIDTH(REG_WIDTH)) u_rc (
    .clk  (clk),
    .rst  (rst),
    .load (wrEnReg[RC_IDX]),
    .inc  (incReg[RC_INC]),
    .d    (bus),
    .q    (rc_q)
  );

  inc_reg #(.WIDTH(REG_WIDTH)) u_rp (
    .clk  (clk),
    .rst  (rst),
    .load (wrEnReg[RP_IDX]),
    .inc  (incReg[RP_INC]),
    .d    (bus),
    .q    (rp_q)
  );

  inc_reg #(.WIDTH(REG_WIDTH)) u_rq (
    .clk  (clk),
    .rst  (rst),
    .load (wrEnReg[RQ_IDX]),
    .inc  (incReg[RQ_INC]),
    .d    (bus),
    .q    (rq_q)
  );

  assign ins         = ir_q;
  assign Zout        = z_q;
  assign dataMemAddr = ar_q;
  assign dataMemIn   = r_q;
  assign insMemAddr  = pc_q;
  assign acOut       = ac_q;

endmodule
